// File: rtl/execute_stage_pipe.sv
// Registered execute stage between register-read and writeback (ALU, shifts, multi-cycle MUL, flags).
// Latency: 1 cycle for single-cycle ops, MUL_CYCLES-1 cycles after accept for MUL.
// Backpressure: a held result freezes all outputs and deasserts in_ready; a MUL blocks input until done.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset (beats flush and everything else)
//   flush             drops in-flight MUL and any held result; blocks accept in that cycle
//   in_valid/in_ready input handshake for inst_in, data1_in, data2_in, imm_in
//   out_valid/out_ready output handshake for result_out, rd_out, reg_write_out, zero_out, carry_out
//   inst_in[15:12]    opcode, inst_in[11:9] destination register
module execute_stage_pipe #(
   parameter int DATA_W     = 16,
   parameter int MUL_CYCLES = 3    // legal range 2..15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       inst_in,
   input  logic [DATA_W-1:0] data1_in,
   input  logic [DATA_W-1:0] data2_in,
   input  logic [DATA_W-1:0] imm_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result_out,
   output logic [2:0]        rd_out,
   output logic              reg_write_out,
   output logic              zero_out,
   output logic              carry_out
);

   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = 4;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_LOAD = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mul_a_q, mul_a_d;
   logic [DATA_W-1:0] mul_b_q, mul_b_d;
   logic [2:0]        mul_rd_q, mul_rd_d;

   logic              out_valid_d;
   logic [DATA_W-1:0] result_d;
   logic [2:0]        rd_d;
   logic              reg_write_d;
   logic              zero_d;
   logic              carry_d;

   // ---------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------
   logic [3:0] opcode;
   logic [2:0] rd_field;
   logic       accept;

   assign opcode   = inst_in[15:12];
   assign rd_field = inst_in[11:9];

   // Low instruction bits carry no meaning for this stage.
   logic unused_inst_bits;
   assign unused_inst_bits = ^inst_in[8:0];

   // rst is folded in so upstream never sees a ready while the stage is being reset.
   assign in_ready = !rst && (state_q == IDLE) && (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   // ---------------------------------------------------------------
   // Single-cycle ALU on the live input operands
   // ---------------------------------------------------------------
   logic [DATA_W:0]   sum_w;
   logic [DATA_W:0]   diff_w;
   logic [SH_W-1:0]   sh_amt;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic              alu_wr;

   assign sum_w  = {1'b0, data1_in} + {1'b0, data2_in};
   // Top bit of the widened difference is the borrow.
   assign diff_w = {1'b0, data1_in} - {1'b0, data2_in};
   assign sh_amt = data2_in[SH_W-1:0];

   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_wr    = 1'b1;
      case (opcode)
         OP_ADD: begin
            alu_res   = sum_w[DATA_W-1:0];
            alu_carry = sum_w[DATA_W];
         end
         OP_SUB: begin
            alu_res   = diff_w[DATA_W-1:0];
            alu_carry = diff_w[DATA_W];
         end
         OP_LOAD: alu_res = data1_in + imm_in;
         OP_AND:  alu_res = data1_in & data2_in;
         OP_OR:   alu_res = data1_in | data2_in;
         OP_XOR:  alu_res = data1_in ^ data2_in;
         OP_SHL:  alu_res = data1_in << sh_amt;
         OP_SHR:  alu_res = data1_in >> sh_amt;
         // MUL never retires through this path; it goes through MUL_BUSY.
         OP_MUL:  alu_res = '0;
         // Unused opcodes still occupy an output slot so ordering is kept,
         // but they write nothing and raise no flags.
         default: alu_wr = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------
   // Multiplier: operands are held stable in mul_a_q/mul_b_q for the
   // whole MUL_BUSY window, so the product path is multicycle.
   // ---------------------------------------------------------------
   logic [2*DATA_W-1:0] prod_w;

   assign prod_w = {{DATA_W{1'b0}}, mul_a_q} * {{DATA_W{1'b0}}, mul_b_q};

   // ---------------------------------------------------------------
   // Next-state and output-register logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_rd_d    = mul_rd_q;
      out_valid_d = out_valid;
      result_d    = result_out;
      rd_d        = rd_out;
      reg_write_d = reg_write_out;
      zero_d      = zero_out;
      carry_d     = carry_out;

      if (flush) begin
         // Data registers are left as-is; only the valid and control state matter.
         state_d     = IDLE;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         // A consumed result frees the slot; a same-edge accept below refills it.
         if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (opcode == OP_MUL) begin
                     state_d  = MUL_BUSY;
                     cnt_d    = CNT_W'(MUL_CYCLES - 1);
                     mul_a_d  = data1_in;
                     mul_b_d  = data2_in;
                     mul_rd_d = rd_field;
                  end else begin
                     out_valid_d = 1'b1;
                     result_d    = alu_res;
                     rd_d        = rd_field;
                     reg_write_d = alu_wr;
                     zero_d      = alu_wr && (alu_res == '0);
                     carry_d     = alu_carry;
                  end
               end
            end

            MUL_BUSY: begin
               // The slot was emptied at accept and nothing else can enter
               // meanwhile, so completion always has somewhere to land.
               if (cnt_q == CNT_W'(1)) begin
                  state_d     = IDLE;
                  cnt_d       = '0;
                  out_valid_d = 1'b1;
                  result_d    = prod_w[DATA_W-1:0];
                  rd_d        = mul_rd_q;
                  reg_write_d = 1'b1;
                  zero_d      = (prod_w[DATA_W-1:0] == '0);
                  carry_d     = |prod_w[2*DATA_W-1:DATA_W];
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         mul_rd_q      <= '0;
         out_valid     <= 1'b0;
         result_out    <= '0;
         rd_out        <= '0;
         reg_write_out <= 1'b0;
         zero_out      <= 1'b0;
         carry_out     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         mul_rd_q      <= mul_rd_d;
         out_valid     <= out_valid_d;
         result_out    <= result_d;
         rd_out        <= rd_d;
         reg_write_out <= reg_write_d;
         zero_out      <= zero_d;
         carry_out     <= carry_d;
      end
   end

endmodule
